instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer end of the instruction-memory / control-unit path: the control unit decodes fetched words, and this block encodes them.
- Accepts decoded instruction fields (ADDI or BNE) over a valid/ready stream.
- Packs each command into a 32-bit RV32I instruction word.
- Writes the words sequentially into instruction memory from a programmable base address.
- Used to load test programs into the CPU instruction memory before releasing the core from reset.

Parameters:
- ADDR_WIDTH, 8, byte-address width of instruction memory write port.
- LEN_WIDTH, 6, width of the program-length count (max 2^LEN_WIDTH-1 instructions per load).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load. Ignored unless state is IDLE.
- base_addr  input  ADDR_WIDTH  byte address of first word. Sampled on accepted start; bits [1:0] forced to 0.
- prog_len  input  LEN_WIDTH  number of instructions to load. Sampled on accepted start.
- cmd_valid  input  1  command fields valid.
- cmd_ready  output  1  loader can accept a command.
- cmd_op  input  1  0 = ADDI, 1 = BNE.
- cmd_rd  input  5  destination register (ADDI only).
- cmd_rs1  input  5  source register 1.
- cmd_rs2  input  5  source register 2 (BNE only).
- cmd_imm  input  12  ADDI: imm[11:0]. BNE: branch offset bits [12:1] (offset bit 0 is implicitly 0).
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  ADDR_WIDTH  byte address of the word being written.
- wr_data  output  32  encoded instruction word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the load completes.

Behaviour:
- Reset (async, rst_n low): state is IDLE.
  - cmd_ready, wr_en, busy and done are 0.
  - wr_addr, wr_data, the address register and the instruction counter are 0.
- States are IDLE, ACCEPT, WRITE and FIN.
- IDLE:
  - On start=1, latch base_addr with bits [1:0] cleared and latch prog_len, then clear the counter.
  - If prog_len==0, go to FIN. Otherwise go to ACCEPT.
- ACCEPT:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register the encoded word into wr_data and go to WRITE.
  - No handshake: stay in ACCEPT with no timeout.
- WRITE:
  - Asserted for exactly one cycle: wr_en=1, wr_addr=address register, cmd_ready=0.
  - Then advance the address register by 4, wrapping modulo 2^ADDR_WIDTH, and increment the counter.
  - If counter+1==prog_len, go to FIN. Otherwise return to ACCEPT.
- FIN: done=1 for one cycle, then go to IDLE.
- Timing:
  - Latency from handshake to wr_en is 1 cycle.
  - Throughput is 1 instruction per 2 cycles.
  - wr_data holds its last value outside WRITE.
- ADDI encoding: {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, 7'b0010011}.
- BNE encoding (B-type): {cmd_imm[11], cmd_imm[9:4], cmd_rs2, cmd_rs1, 3'b001, cmd_imm[3:0], cmd_imm[10], 7'b1100011}.
- Ignored fields: cmd_rs2 is ignored for ADDI and cmd_rd is ignored for BNE.
- start while busy is ignored, with no effect on the latched base_addr or prog_len.
- Address wrap-around: after address 2^ADDR_WIDTH-4, the next word goes to 0. No error is flagged.
- Reset mid-load aborts immediately. wr_en drops asynchronously and no partial word is written after reset release.
- cmd_valid while not in ACCEPT is not acknowledged. The source must hold the command until it sees cmd_ready.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> wr_en, cmd_ready, busy, done = 0 immediately. start ignored while rst_n low.
- Single ADDI: start with base=0x00, len=1; ADDI rd=1, rs1=0, imm=0x0FF -> one wr_en pulse at wr_addr=0x00 with wr_data=0x0FF00093, then done pulse, busy low.
- BNE encode: BNE rs1=1, rs2=0, cmd_imm=0xFFE (offset -4) -> wr_data=0xFE009EE3.
- Backpressure/sequence: len=3 with cmd_valid stalled 5 cycles between commands -> writes at 0x10, 0x14, 0x18 in order. cmd_ready is never high during WRITE. Exactly 3 wr_en pulses.
- Boundaries:
  - base=0xFC, len=2 with ADDR_WIDTH=8 -> writes at 0xFC then 0x00.
  - len=0 -> done one cycle after start, with no wr_en.
  - start pulsed during busy -> no change.
- Reset mid-load: assert rst_n low after 1 of 3 writes -> outputs clear. A fresh start loads from the new base with the counter at 0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Packs decoded ADDI / BNE command fields into RV32I instruction words and
//   writes them sequentially into instruction memory from a programmable
//   base address. Used to preload test programs before the core leaves reset.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse that begins a load (honoured only in IDLE)
//   base_addr  byte address of the first word, bits [1:0] forced to 0
//   prog_len   number of instructions to load (0 = finish immediately)
//   cmd_valid  command fields valid
//   cmd_ready  loader can accept a command
//   cmd_op     0 = ADDI, 1 = BNE
//   cmd_rd     destination register (ADDI)
//   cmd_rs1    source register 1
//   cmd_rs2    source register 2 (BNE)
//   cmd_imm    ADDI imm[11:0] / BNE offset bits [12:1]
//   wr_en      instruction memory write strobe
//   wr_addr    byte address of the word being written
//   wr_data    encoded instruction word
//   busy       high in every state except IDLE
//   done       one-cycle pulse at load completion
//
// State table
//   state  | meaning
//   IDLE   | waiting for start
//   ACCEPT | cmd_ready high, waiting for a command handshake
//   WRITE  | one-cycle write of the encoded word, then advance address/count
//   FIN    | done pulse, then back to IDLE

module instr_mem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  prog_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [4:0]            cmd_rd,
    input  logic [4:0]            cmd_rs1,
    input  logic [4:0]            cmd_rs2,
    input  logic [11:0]           cmd_imm,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  cnt_inc;
    logic [31:0]           enc_word;

    // cmd_imm carries offset[12:1] for BNE, so B-type bit positions shift
    // down by one relative to the usual imm[12|10:5|4:1|11] notation.
    always_comb begin
        enc_word = 32'd0;
        if (cmd_op) begin
            enc_word = {cmd_imm[11], cmd_imm[9:4], cmd_rs2, cmd_rs1, 3'b001,
                        cmd_imm[3:0], cmd_imm[10], 7'b1100011};
        end else begin
            enc_word = {cmd_imm, cmd_rs1, 3'b000, cmd_rd, 7'b0010011};
        end
    end

    assign cnt_inc = cnt + LEN_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                        len_q  <= prog_len;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (prog_len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= ACCEPT;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    if (cmd_valid && cmd_ready) begin
                        wr_data   <= enc_word;
                        wr_addr   <= addr_q;
                        wr_en     <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en  <= 1'b0;
                    // Wraps naturally modulo 2^ADDR_WIDTH.
                    addr_q <= addr_q + ADDR_WIDTH'(4);
                    cnt    <= cnt_inc;
                    if (cnt_inc == len_q) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state     <= ACCEPT;
                        cmd_ready <= 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    wr_en     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
//   Directed bench for instr_mem_loader: encodings, addressing, wrap,
//   zero-length loads, start-while-busy and reset mid-load.

module tb_instr_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [5:0]  prog_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [11:0] cmd_imm;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_overlap = 0;

    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];

    instr_mem_loader #(.ADDR_WIDTH(8), .LEN_WIDTH(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .prog_len  (prog_len),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log and ready/write overlap monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            if (cmd_ready) n_overlap++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        n_overlap = 0;
    endtask

    task automatic start_load(input logic [7:0] b, input logic [5:0] l);
        base_addr = b;
        prog_len  = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Presents one command after 'stall' idle cycles and waits for the
    // handshake; on acceptance the write strobe must follow on the next cycle.
    task automatic send_cmd(input string tag, input logic op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [11:0] imm, input int stall);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < stall; i++) tick();
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        chk({tag, "_accepted"}, 32'(ok), 32'd1);
        chk({tag, "_wr_en_latency"}, 32'(wr_en), 32'd1);
        chk({tag, "_ready_in_write"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b1;
        base_addr = 8'h00;
        prog_len  = 6'd1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_rd    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        cmd_imm   = '0;

        // Reset with start held high: nothing may move.
        repeat (3) tick();
        chk("rst_wr_en",     32'(wr_en), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_done",      32'(done), 32'd0);
        chk("rst_wr_addr",   32'(wr_addr), 32'd0);
        chk("rst_wr_data",   wr_data, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Single ADDI at base 0.
        clear_log();
        start_load(8'h00, 6'd1);
        chk("addi_busy", 32'(busy), 32'd1);
        chk("addi_ready", 32'(cmd_ready), 32'd1);
        send_cmd("addi", 1'b0, 5'd1, 5'd0, 5'd7, 12'h0FF, 0);
        wait_done("addi");
        chk("addi_count", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() == 1) begin
            chk("addi_addr", 32'(q_addr[0]), 32'h00);
            chk("addi_data", q_data[0], 32'h0FF00093);
        end
        chk("addi_data_hold", wr_data, 32'h0FF00093);

        // BNE encode, rd field ignored.
        clear_log();
        start_load(8'h40, 6'd1);
        send_cmd("bne", 1'b1, 5'd9, 5'd1, 5'd0, 12'hFFE, 1);
        wait_done("bne");
        chk("bne_count", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() == 1) begin
            chk("bne_addr", 32'(q_addr[0]), 32'h40);
            chk("bne_data", q_data[0], 32'hFE009EE3);
        end

        // Three commands with 5-cycle stalls, plus a start pulse while busy.
        clear_log();
        start_load(8'h10, 6'd3);
        send_cmd("seq0", 1'b0, 5'd2, 5'd1, 5'd0, 12'h005, 5);
        base_addr = 8'h80;
        prog_len  = 6'd1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        send_cmd("seq1", 1'b1, 5'd0, 5'd2, 5'd3, 12'h004, 5);
        send_cmd("seq2", 1'b0, 5'd31, 5'd31, 5'd0, 12'h800, 5);
        wait_done("seq");
        chk("seq_count", 32'(q_addr.size()), 32'd3);
        chk("seq_overlap", 32'(n_overlap), 32'd0);
        if (q_addr.size() == 3) begin
            chk("seq_addr0", 32'(q_addr[0]), 32'h10);
            chk("seq_addr1", 32'(q_addr[1]), 32'h14);
            chk("seq_addr2", 32'(q_addr[2]), 32'h18);
            chk("seq_data0", q_data[0], 32'h00508113);
            chk("seq_data1", q_data[1], 32'h00311463);
            chk("seq_data2", q_data[2], 32'h800F8F93);
        end

        // Wrap from 0xFC to 0x00; low address bits dropped.
        clear_log();
        start_load(8'hFE, 6'd2);
        send_cmd("wrap0", 1'b0, 5'd1, 5'd0, 5'd0, 12'h001, 0);
        send_cmd("wrap1", 1'b0, 5'd0, 5'd0, 5'd0, 12'h000, 2);
        wait_done("wrap");
        chk("wrap_count", 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            chk("wrap_addr0", 32'(q_addr[0]), 32'hFC);
            chk("wrap_addr1", 32'(q_addr[1]), 32'h00);
            chk("wrap_data0", q_data[0], 32'h00100093);
            chk("wrap_data1", q_data[1], 32'h00000013);
        end

        // Zero-length load.
        clear_log();
        start_load(8'h20, 6'd0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd1);
        chk("len0_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("len0_done_clr", 32'(done), 32'd0);
        chk("len0_busy_clr", 32'(busy), 32'd0);
        chk("len0_no_write", 32'(q_addr.size()), 32'd0);

        // Reset mid-load while the first write strobe is up.
        clear_log();
        start_load(8'h20, 6'd3);
        send_cmd("rstmid", 1'b0, 5'd3, 5'd3, 5'd0, 12'h123, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_wr_en",   32'(wr_en), 32'd0);
        chk("rstmid_busy",    32'(busy), 32'd0);
        chk("rstmid_ready",   32'(cmd_ready), 32'd0);
        chk("rstmid_wr_data", wr_data, 32'd0);
        chk("rstmid_wr_addr", 32'(wr_addr), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rstmid_idle_busy", 32'(busy), 32'd0);
        clear_log();
        start_load(8'h30, 6'd2);
        send_cmd("fresh0", 1'b0, 5'd4, 5'd5, 5'd0, 12'h010, 0);
        send_cmd("fresh1", 1'b0, 5'd6, 5'd7, 5'd0, 12'h020, 0);
        wait_done("fresh");
        chk("fresh_count", 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            chk("fresh_addr0", 32'(q_addr[0]), 32'h30);
            chk("fresh_addr1", 32'(q_addr[1]), 32'h34);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
